// File: rtl/mult_div_iter_unit_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Contents: RV32M/RV64M funct3 op encoding, FSM state constants,
// op classification helpers used by the unit and its callers.
package mult_div_iter_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mult_div_op_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_div(mult_div_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(mult_div_op_e op);
    return op[2] & op[1];
  endfunction

  // MUL is treated as signed/signed; its low half is identical either way.
  function automatic logic is_signed1(mult_div_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed2(mult_div_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mult_div_iter_unit_if.sv
// Issue/result handshake bundle between the mult/div reservation station,
// the execution unit and the CDB arbiter.
//   in_valid/in_ready/in_op/in_src1/in_src2/in_tag : issue side
//   out_valid/out_ready/out_result/out_tag        : result side
//   busy                                          : unit not idle
// Modports: master = station/arbiter side, slave = execution unit.
interface mult_div_iter_unit_if
  import mult_div_iter_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 8
) ();

  logic                 in_valid;
  logic                 in_ready;
  mult_div_op_e         in_op;
  logic [XLEN-1:0]      in_src1;
  logic [XLEN-1:0]      in_src2;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_result;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 busy;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );

endinterface

// File: rtl/mult_div_iter_unit.sv
// Iterative RV32M/RV64M multiply/divide unit. One op in flight; radix-2
// shift-add multiply and restoring divide over XLEN cycles, result and tag
// held until the CDB arbiter grants the bus.
// Ports:
//   clk   : clock
//   reset : asynchronous reset, active-high
//   flush : synchronous abort of any in-flight op
//   bus   : slave side of mult_div_iter_unit_if (issue + result handshake)
//
// state  | meaning
// IDLE   | waiting for an op, in_ready=1
// CALC   | one radix-2 step per cycle, counter runs XLEN..1
// DONE   | sign-fixed result held, out_valid=1 until out_ready
module mult_div_iter_unit
  import mult_div_iter_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  mult_div_iter_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  mult_div_op_e         op_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 neg_q;
  logic [XLEN-1:0]      b_q;
  // Multiply: {high, low} product, low half starts as the multiplier.
  // Divide:   {remainder, quotient}, quotient half starts as the dividend.
  logic [2*XLEN-1:0]    acc_q;
  logic [XLEN-1:0]      res_q;

  logic                 s1, s2, neg_in;
  logic [XLEN-1:0]      a_mag, b_mag;
  logic                 div_zero, div_ovf, special;
  logic [XLEN-1:0]      special_res;
  logic [XLEN:0]        sum, rshift, diff;
  logic [2*XLEN-1:0]    acc_step, prod_fix;
  logic [XLEN-1:0]      quo, rem, final_res;

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.out_valid  = (state == S_DONE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.out_result = res_q;
  assign bus.out_tag    = tag_q;

  // Operand preparation and early-out detection for the accept cycle.
  always_comb begin
    s1       = is_signed1(bus.in_op) && bus.in_src1[XLEN-1];
    s2       = is_signed2(bus.in_op) && bus.in_src2[XLEN-1];
    a_mag    = s1 ? -bus.in_src1 : bus.in_src1;
    b_mag    = s2 ? -bus.in_src2 : bus.in_src2;
    neg_in   = is_rem(bus.in_op) ? s1 : (s1 ^ s2);
    div_zero = is_div(bus.in_op) && (bus.in_src2 == '0);
    div_ovf  = ((bus.in_op == OP_DIV) || (bus.in_op == OP_REM)) &&
               (bus.in_src1 == MIN_NEG) && (&bus.in_src2);
    special  = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = is_rem(bus.in_op) ? bus.in_src1 : '1;
    else if (div_ovf)
      special_res = (bus.in_op == OP_DIV) ? bus.in_src1 : '0;
  end

  // One radix-2 step plus the sign-fixed result of that step, so the final
  // step's result can be registered on the CALC->DONE edge.
  always_comb begin
    sum      = '0;
    rshift   = '0;
    diff     = '0;
    acc_step = acc_q;
    if (is_div(op_q)) begin
      rshift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff   = rshift - {1'b0, b_q};
      if (!diff[XLEN])
        acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
        acc_step = {rshift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      // Carry out of the add lands in the top bit of the shifted accumulator.
      sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, b_q} & {(XLEN+1){acc_q[0]}});
      acc_step = {sum, acc_q[XLEN-1:1]};
    end

    prod_fix = neg_q ? -acc_step : acc_step;
    quo      = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem      = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = quo;
      default:                       final_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= OP_MUL;
      tag_q <= '0;
      neg_q <= 1'b0;
      b_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.in_op;
            tag_q <= bus.in_tag;
            neg_q <= neg_in;
            b_q   <= b_mag;
            acc_q <= {{XLEN{1'b0}}, a_mag};
            if (special) begin
              res_q <= special_res;
              cnt   <= '0;
              state <= S_DONE;
            end else begin
              cnt   <= CW'(XLEN);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_step;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res_q <= final_res;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
